// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 key sequencer.
package ps2_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_BREAK     = 2'd1,
        S_EXT       = 2'd2,
        S_EXT_BREAK = 2'd3
    } ps2_state_e;

    localparam logic [7:0] CODE_BREAK  = 8'hF0;
    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;

    typedef struct packed {
        logic       ext;
        logic       shift;
        logic [7:0] code;
    } key_entry_t;

    localparam int unsigned KEY_ENTRY_W = $bits(key_entry_t);

endpackage

// File: rtl/ps2_key_sequencer_if.sv
// Key-event bus between the sequencer and its scan-code source / consumer.
interface ps2_key_sequencer_if #(
    parameter int unsigned FIFO_DEPTH = 8
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]       PS2_code;
    logic             PS2_code_ready;
    logic             Key_pop;
    logic             Clear_overflow;
    logic             Key_valid;
    logic [7:0]       Key_code;
    logic             Key_extended;
    logic             Key_shift;
    logic [CNT_W-1:0] Key_count;
    logic             Overflow;

    modport master (
        input  PS2_code, PS2_code_ready, Key_pop, Clear_overflow,
        output Key_valid, Key_code, Key_extended, Key_shift, Key_count, Overflow
    );

    modport slave (
        output PS2_code, PS2_code_ready, Key_pop, Clear_overflow,
        input  Key_valid, Key_code, Key_extended, Key_shift, Key_count, Overflow
    );
endinterface

// File: rtl/ps2_key_fifo.sv
// Show-ahead FIFO for decoded key events; a pop on a full FIFO frees room for a same-cycle push.
module ps2_key_fifo #(
    parameter  int unsigned DEPTH = 8,
    parameter  int unsigned WIDTH = 10,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/ps2_key_sequencer.sv
// Decodes PS/2 set-2 make/break/extended sequences into key events with shift state, buffered in a FIFO.
module ps2_key_sequencer
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                        Clock_50,
    input  logic                        Reset,
    ps2_key_sequencer_if.master         key_bus
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    ps2_state_e       state, state_n;
    logic             lshift, lshift_n;
    logic             rshift, rshift_n;
    logic             ready_d;
    logic             overflow;
    logic             new_code_c;
    logic             push_c;
    logic             drop_c;
    key_entry_t       entry_c;
    key_entry_t       head_c;
    logic [KEY_ENTRY_W-1:0] fifo_rd;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    assign new_code_c = key_bus.PS2_code_ready && !ready_d;
    assign drop_c     = push_c && fifo_full && !key_bus.Key_pop;

    // ready_d resets high so a level already present at reset release is not a new code
    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            state    <= S_IDLE;
            lshift   <= 1'b0;
            rshift   <= 1'b0;
            ready_d  <= 1'b1;
            overflow <= 1'b0;
        end else begin
            state   <= state_n;
            lshift  <= lshift_n;
            rshift  <= rshift_n;
            ready_d <= key_bus.PS2_code_ready;
            if (drop_c)                      overflow <= 1'b1;
            else if (key_bus.Clear_overflow) overflow <= 1'b0;
        end
    end

    always_comb begin
        state_n       = state;
        lshift_n      = lshift;
        rshift_n      = rshift;
        push_c        = 1'b0;
        entry_c.ext   = 1'b0;
        entry_c.shift = lshift || rshift;
        entry_c.code  = key_bus.PS2_code;
        if (new_code_c) begin
            unique case (state)
                S_IDLE: begin
                    case (key_bus.PS2_code)
                        CODE_BREAK:  state_n  = S_BREAK;
                        CODE_EXT:    state_n  = S_EXT;
                        CODE_LSHIFT: lshift_n = 1'b1;
                        CODE_RSHIFT: rshift_n = 1'b1;
                        default:     push_c   = 1'b1;
                    endcase
                end
                S_BREAK: begin
                    if (key_bus.PS2_code == CODE_LSHIFT) lshift_n = 1'b0;
                    if (key_bus.PS2_code == CODE_RSHIFT) rshift_n = 1'b0;
                    state_n = S_IDLE;
                end
                S_EXT: begin
                    case (key_bus.PS2_code)
                        CODE_BREAK: state_n = S_EXT_BREAK;
                        CODE_EXT:   state_n = S_EXT;
                        default: begin
                            push_c      = 1'b1;
                            entry_c.ext = 1'b1;
                            state_n     = S_IDLE;
                        end
                    endcase
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    ps2_key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (KEY_ENTRY_W)
    ) u_fifo (
        .clk     (Clock_50),
        .rst     (Reset),
        .push    (push_c),
        .pop     (key_bus.Key_pop),
        .wr_data (entry_c),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Head fields read as zero whenever nothing is queued
    assign head_c = fifo_empty ? key_entry_t'('0) : key_entry_t'(fifo_rd);

    assign key_bus.Key_valid    = !fifo_empty;
    assign key_bus.Key_code     = head_c.code;
    assign key_bus.Key_extended = head_c.ext;
    assign key_bus.Key_shift    = head_c.shift;
    assign key_bus.Key_count    = fifo_count;
    assign key_bus.Overflow     = overflow;
endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed bench for ps2_key_sequencer: queue-based key-event model checked every cycle plus literal spot checks.
module tb_ps2_key_sequencer;
    localparam int unsigned DEPTH = 8;

    logic Clock_50 = 1'b0;
    logic Reset    = 1'b1;
    always #10 Clock_50 = ~Clock_50;

    ps2_key_sequencer_if #(.FIFO_DEPTH(DEPTH)) kb ();

    ps2_key_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
        .Clock_50 (Clock_50),
        .Reset    (Reset),
        .key_bus  (kb)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of {ext, shift, code} plus pending-prefix and shift flags
    logic [9:0] mq[$];
    bit         m_ovf, m_brk, m_ext, m_ls, m_rs, m_prev, m_live;
    bit         fresh, want_push;
    logic [7:0] code;
    logic [9:0] ent;

    always @(posedge Clock_50) begin
        if (Reset) begin
            mq.delete();
            m_ovf = 0; m_brk = 0; m_ext = 0; m_ls = 0; m_rs = 0;
            m_prev = 1; m_live = 1;
        end else begin
            fresh     = kb.PS2_code_ready && !m_prev;
            m_prev    = kb.PS2_code_ready;
            want_push = 0;
            ent       = '0;
            if (fresh) begin
                code = kb.PS2_code;
                if (m_brk) begin
                    if (!m_ext && code == 8'h12) m_ls = 0;
                    if (!m_ext && code == 8'h59) m_rs = 0;
                    m_brk = 0;
                    m_ext = 0;
                end else if (code == 8'hF0) m_brk = 1;
                else if (code == 8'hE0) m_ext = 1;
                else if (!m_ext && code == 8'h12) m_ls = 1;
                else if (!m_ext && code == 8'h59) m_rs = 1;
                else begin
                    ent       = {m_ext, m_ls | m_rs, code};
                    want_push = 1;
                    m_ext     = 0;
                end
            end
            if (kb.Key_pop && mq.size() > 0) void'(mq.pop_front());
            if (kb.Clear_overflow) m_ovf = 0;
            if (want_push) begin
                if (mq.size() < int'(DEPTH)) mq.push_back(ent);
                else m_ovf = 1;
            end
        end
    end

    always @(negedge Clock_50) begin
        if (m_live) begin
            logic [9:0] head;
            head = (mq.size() != 0) ? mq[0] : 10'd0;
            chk("valid",    32'(kb.Key_valid),    32'(mq.size() != 0));
            chk("code",     32'(kb.Key_code),     32'(head[7:0]));
            chk("extended", 32'(kb.Key_extended), 32'(head[9]));
            chk("shift",    32'(kb.Key_shift),    32'(head[8]));
            chk("count",    32'(kb.Key_count),    32'(mq.size()));
            chk("overflow", 32'(kb.Overflow),     32'(m_ovf));
        end
    end

    task automatic tick();
        @(negedge Clock_50);
    endtask

    task automatic send(input logic [7:0] c);
        kb.PS2_code       = c;
        kb.PS2_code_ready = 1'b1;
        tick(); tick();
        kb.PS2_code_ready = 1'b0;
        tick(); tick();
    endtask

    task automatic pop_one();
        kb.Key_pop = 1'b1;
        tick();
        kb.Key_pop = 1'b0;
        tick();
    endtask

    initial begin
        kb.PS2_code       = 8'h00;
        kb.PS2_code_ready = 1'b0;
        kb.Key_pop        = 1'b0;
        kb.Clear_overflow = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 32'(kb.Key_valid), 32'd0);
        chk("rst_count", 32'(kb.Key_count), 32'd0);
        chk("rst_ovf",   32'(kb.Overflow),  32'd0);
        chk("rst_code",  32'(kb.Key_code),  32'd0);
        Reset = 1'b0;
        tick();

        // 1C, F0, 1C: one plain entry, valid one cycle after the ready edge
        kb.PS2_code = 8'h1C; kb.PS2_code_ready = 1'b1;
        tick();
        chk("lat_valid", 32'(kb.Key_valid), 32'd1);
        tick();
        kb.PS2_code_ready = 1'b0;
        tick(); tick();
        send(8'hF0); send(8'h1C);
        chk("mk_count", 32'(kb.Key_count),    32'd1);
        chk("mk_code",  32'(kb.Key_code),     32'h1C);
        chk("mk_ext",   32'(kb.Key_extended), 32'd0);
        chk("mk_shift", 32'(kb.Key_shift),    32'd0);
        pop_one();
        chk("mk_empty_code", 32'(kb.Key_code), 32'd0);

        // Shift held then released
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
        chk("sh_count",  32'(kb.Key_count), 32'd2);
        chk("sh_shift1", 32'(kb.Key_shift), 32'd1);
        pop_one();
        chk("sh_shift0", 32'(kb.Key_shift), 32'd0);
        chk("sh_code2",  32'(kb.Key_code),  32'h1C);
        pop_one();

        // Extended make, extended break, then a plain make
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        chk("ext_count", 32'(kb.Key_count),    32'd1);
        chk("ext_code",  32'(kb.Key_code),     32'h75);
        chk("ext_flag",  32'(kb.Key_extended), 32'd1);
        send(8'h1C);
        pop_one();
        chk("ext_idle",  32'(kb.Key_extended), 32'd0);
        pop_one();

        // Fill past capacity
        for (int i = 0; i < 9; i++) send(8'(8'h20 + i));
        chk("full_count", 32'(kb.Key_count), 32'd8);
        chk("full_ovf",   32'(kb.Overflow),  32'd1);
        chk("full_head",  32'(kb.Key_code),  32'h20);
        kb.PS2_code = 8'h30; kb.PS2_code_ready = 1'b1; kb.Key_pop = 1'b1;
        tick();
        kb.Key_pop = 1'b0;
        chk("pp_count", 32'(kb.Key_count), 32'd8);
        chk("pp_head",  32'(kb.Key_code),  32'h21);
        tick();
        kb.PS2_code_ready = 1'b0;
        tick(); tick();
        kb.Clear_overflow = 1'b1;
        tick();
        kb.Clear_overflow = 1'b0;
        chk("clr_ovf", 32'(kb.Overflow), 32'd0);
        // Clear coinciding with a dropped push: set wins
        kb.PS2_code = 8'h31; kb.PS2_code_ready = 1'b1; kb.Clear_overflow = 1'b1;
        tick();
        kb.Clear_overflow = 1'b0;
        chk("clr_vs_drop", 32'(kb.Overflow), 32'd1);
        kb.PS2_code_ready = 1'b0;
        tick(); tick();
        kb.Clear_overflow = 1'b1;
        tick();
        kb.Clear_overflow = 1'b0;
        kb.Key_pop = 1'b1;
        repeat (7) tick();
        chk("drain_tail", 32'(kb.Key_code), 32'h30);
        tick();
        kb.Key_pop = 1'b0;
        chk("drain_empty", 32'(kb.Key_count), 32'd0);
        // Pop on empty ignored while the push lands
        kb.PS2_code = 8'h33; kb.PS2_code_ready = 1'b1; kb.Key_pop = 1'b1;
        tick();
        kb.Key_pop = 1'b0;
        chk("ep_count", 32'(kb.Key_count), 32'd1);
        chk("ep_code",  32'(kb.Key_code),  32'h33);
        kb.PS2_code_ready = 1'b0;
        tick(); tick();
        pop_one();

        // Ready high through reset release is not a new code
        Reset = 1'b1; kb.PS2_code = 8'h1C; kb.PS2_code_ready = 1'b1;
        tick(); tick();
        Reset = 1'b0;
        tick(); tick();
        chk("rr_count", 32'(kb.Key_count), 32'd0);
        kb.PS2_code_ready = 1'b0;
        tick(); tick();
        // Reset after a break prefix discards it
        send(8'hF0);
        Reset = 1'b1; tick(); Reset = 1'b0; tick();
        send(8'h1C);
        chk("rb_count", 32'(kb.Key_count),    32'd1);
        chk("rb_code",  32'(kb.Key_code),     32'h1C);
        chk("rb_ext",   32'(kb.Key_extended), 32'd0);
        pop_one();
        // Reset after extended prefix and after shift press
        send(8'hE0);
        Reset = 1'b1; tick(); Reset = 1'b0; tick();
        send(8'h75);
        chk("re_ext", 32'(kb.Key_extended), 32'd0);
        pop_one();
        send(8'h12);
        Reset = 1'b1; tick(); Reset = 1'b0; tick();
        send(8'h1C);
        chk("rs_shift", 32'(kb.Key_shift), 32'd0);
        pop_one();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_key_sequencer.md
PS2_KEY_SEQUENCER -- requirements
Module: ps2_key_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, number of key-event entries buffered; SHALL be a power of two, minimum 2.
REQ-002 Clock_50  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 PS2_code  input  8  last assembled scan code from the PS2 receiver.
REQ-005 PS2_code_ready  input  1  receiver level flag; it rises when a new code is valid and falls at the next start bit.
REQ-006 Key_pop  input  1  consumer acknowledges the head entry.
REQ-007 Clear_overflow  input  1  clears the sticky Overflow flag.
REQ-008 Key_valid  output  1  FIFO non-empty; head entry is presented.
REQ-009 Key_code  output  8  head entry scan code.
REQ-010 Key_extended  output  1  head entry was E0-prefixed.
REQ-011 Key_shift  output  1  shift state captured with the head entry.
REQ-012 Key_count  output  clog2(FIFO_DEPTH)+1  current number of entries.
REQ-013 Overflow  output  1  sticky flag; a key event was dropped.

Function
REQ-014 new_code SHALL be PS2_code_ready AND NOT ready_d, where ready_d is PS2_code_ready registered one cycle.
REQ-015 The decoder FSM SHALL act only in cycles where new_code=1; otherwise it SHALL hold state.
REQ-016 FSM states: S_IDLE, S_BREAK, S_EXT, S_EXT_BREAK.
REQ-017 S_IDLE: F0 -> S_BREAK; E0 -> S_EXT; 12 -> set lshift, no push; 59 -> set rshift, no push; any other code -> push {ext=0, shift, code}, stay in S_IDLE.
REQ-018 S_BREAK: 12 -> clear lshift; 59 -> clear rshift; any other code discarded; then -> S_IDLE.
REQ-019 S_EXT: F0 -> S_EXT_BREAK; E0 -> stay in S_EXT; any other code -> push {ext=1, shift, code}, then -> S_IDLE.
REQ-020 S_EXT_BREAK: any code discarded -> S_IDLE.
REQ-021 The shift value stored SHALL be lshift OR rshift as held before the current code is applied.
REQ-022 A push SHALL write the FIFO on the same edge that new_code is sampled; Key_valid SHALL be high in the next cycle (latency 1 cycle).
REQ-023 The FIFO SHALL be show-ahead: Key_code, Key_extended and Key_shift reflect the head entry whenever Key_valid=1.
REQ-024 Key_pop with Key_valid=1 SHALL remove the head on that edge; Key_pop with Key_valid=0 SHALL be ignored.
REQ-025 Push while full and no pop: the entry SHALL be dropped, Key_count unchanged, and Overflow set.
REQ-026 Push while full with a simultaneous pop SHALL succeed; Key_count stays at FIFO_DEPTH.
REQ-027 Simultaneous push and pop when not empty SHALL leave Key_count unchanged; when empty, the push SHALL occur and the pop SHALL be ignored.
REQ-028 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 Clear_overflow SHALL clear Overflow; if it coincides with a dropping push, Overflow SHALL end that cycle at 1 (set wins).

Reset
REQ-030 Reset SHALL put the FSM in S_IDLE, clear lshift and rshift, empty the FIFO, and force Key_valid=0, Key_count=0 and Overflow=0.
REQ-031 Reset SHALL set ready_d to 1, so a PS2_code_ready that is already high at reset release is not treated as a new code.
REQ-032 Reset asserted mid-sequence (after F0 or E0) SHALL discard the pending prefix.
REQ-033 Key_code, Key_extended and Key_shift SHALL read 0 while the FIFO is empty after reset.

Structure
REQ-034 The package ps2_pkg SHALL hold the FSM state enum and the scan-code constants F0, E0, 12 and 59.
REQ-035 The FIFO SHALL be the sub-module ps2_key_fifo, 10 bits wide and FIFO_DEPTH deep, with full, empty and count outputs.

Verification
REQ-036 Codes 1C, F0, 1C -> exactly one entry {1C, ext=0, shift=0}; Key_valid rises 1 cycle after the first ready edge.
REQ-037 Codes 12, 1C, F0, 12, 1C -> entries {1C, shift=1} then {1C, shift=0}; no entry for 12.
REQ-038 Codes E0, 75, E0, F0, 75 -> one entry {75, ext=1}; the FSM ends in S_IDLE.
REQ-039 With Key_pop held at 0, 9 make codes -> Key_count=8 and Overflow=1; then push together with pop -> Key_count stays 8; then Clear_overflow -> Overflow=0.
REQ-040 PS2_code_ready high through Reset release, and Reset asserted after F0 -> no entry is pushed; the next 1C is pushed as a make code.
